// File: rtl/wb_init_master_if.sv
// Command, data-stream, status and Wishbone signal bundle for wb_init_master.
interface wb_init_master_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned LW = 8;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [SW-1:0] cmd_sel;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          err;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [SW-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_sel, cmd_len, wr_data, wr_valid,
           wb_dat_i, wb_ack_i, wb_err_i,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_sel, cmd_len, wr_data, wr_valid,
           wb_dat_i, wb_ack_i, wb_err_i,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
  );
endinterface

// File: rtl/wb_init_master.sv
// Burst Wishbone initiator: one command -> 1..256 incrementing beats, done/err status.
// Optional per-beat ack timeout enabled by defining WB_INIT_MASTER_TIMEOUT_EN.
module wb_init_master #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_resetn,
  wb_init_master_if.master  bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 9;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("wb_init_master: TIMEOUT_CYC must be within 2..65535");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WDAT, ST_BUS, ST_FIN} state_t;

  state_t        r_state,     w_state_nx;
  logic          r_cmd_ready, w_cmd_ready_nx;
  logic          r_wr_ready,  w_wr_ready_nx;
  logic          r_rd_valid,  w_rd_valid_nx;
  logic          r_done,      w_done_nx;
  logic          r_err,       w_err_nx;
  logic          r_cyc,       w_cyc_nx;
  logic          r_stb,       w_stb_nx;
  logic          r_we,        w_we_nx;
  logic [AW-1:0] r_adr,       w_adr_nx;
  logic [SW-1:0] r_sel,       w_sel_nx;
  logic [DW-1:0] r_dat_o,     w_dat_o_nx;
  logic [DW-1:0] r_rd_data,   w_rd_data_nx;
  logic [CW-1:0] r_beats,     w_beats_nx;

  logic w_ack;
  logic w_abort;
  logic w_last;
  logic w_timeout;

  // Responses only count while stb is high; err wins over a simultaneous ack.
  assign w_abort = r_stb & bus.wb_err_i;
  assign w_ack   = r_stb & bus.wb_ack_i & ~bus.wb_err_i;
  assign w_last  = (r_beats == CW'(1));

`ifdef WB_INIT_MASTER_TIMEOUT_EN
  localparam int unsigned TW = 16;
  logic [TW-1:0] r_to_cnt;

  // Cycles stb has waited in the current beat; restarts on stb rise and on every ack.
  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      r_to_cnt <= '0;
    end else if (r_stb && w_stb_nx && !w_ack) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = r_stb && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_sel       <= '0;
      r_dat_o     <= '0;
      r_rd_data   <= '0;
      r_beats     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cmd_ready <= w_cmd_ready_nx;
      r_wr_ready  <= w_wr_ready_nx;
      r_rd_valid  <= w_rd_valid_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
      r_cyc       <= w_cyc_nx;
      r_stb       <= w_stb_nx;
      r_we        <= w_we_nx;
      r_adr       <= w_adr_nx;
      r_sel       <= w_sel_nx;
      r_dat_o     <= w_dat_o_nx;
      r_rd_data   <= w_rd_data_nx;
      r_beats     <= w_beats_nx;
    end
  end

  // Next state and next output values.
  always_comb begin
    w_state_nx    = r_state;
    w_cyc_nx      = r_cyc;
    w_stb_nx      = r_stb;
    w_we_nx       = r_we;
    w_adr_nx      = r_adr;
    w_sel_nx      = r_sel;
    w_dat_o_nx    = r_dat_o;
    w_rd_data_nx  = r_rd_data;
    w_beats_nx    = r_beats;
    w_rd_valid_nx = 1'b0;
    w_done_nx     = 1'b0;
    w_err_nx      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_we_nx    = bus.cmd_we;
          w_adr_nx   = bus.cmd_addr;
          w_sel_nx   = bus.cmd_sel;
          w_beats_nx = CW'(bus.cmd_len) + CW'(1);
          if (bus.cmd_we) begin
            w_state_nx = ST_WDAT;
          end else begin
            w_state_nx = ST_BUS;
            w_cyc_nx   = 1'b1;
            w_stb_nx   = 1'b1;
          end
        end
      end

      ST_WDAT: begin
        if (bus.wr_valid && r_wr_ready) begin
          w_dat_o_nx = bus.wr_data;
          w_state_nx = ST_BUS;
          w_cyc_nx   = 1'b1;
          w_stb_nx   = 1'b1;
        end
      end

      ST_BUS: begin
        if (w_abort || w_timeout) begin
          w_state_nx = ST_IDLE;
          w_cyc_nx   = 1'b0;
          w_stb_nx   = 1'b0;
          w_we_nx    = 1'b0;
          w_err_nx   = 1'b1;
        end else if (w_ack) begin
          w_adr_nx   = r_adr + AW'(4);
          w_beats_nx = r_beats - CW'(1);
          if (!r_we) begin
            w_rd_data_nx  = bus.wb_dat_i;
            w_rd_valid_nx = 1'b1;
          end
          if (w_last) begin
            w_state_nx = ST_FIN;
            w_cyc_nx   = 1'b0;
            w_stb_nx   = 1'b0;
            w_we_nx    = 1'b0;
            w_done_nx  = 1'b1;
          end else if (r_we) begin
            // Keep the cycle open while the next write word is fetched.
            w_state_nx = ST_WDAT;
            w_stb_nx   = 1'b0;
          end
        end
      end

      ST_FIN: begin
        w_state_nx = ST_IDLE;
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    w_cmd_ready_nx = (w_state_nx == ST_IDLE);
    w_wr_ready_nx  = (w_state_nx == ST_WDAT);
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.wr_ready  = r_wr_ready;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.wb_cyc_o  = r_cyc;
  assign bus.wb_stb_o  = r_stb;
  assign bus.wb_we_o   = r_we;
  assign bus.wb_adr_o  = r_adr;
  assign bus.wb_sel_o  = r_sel;
  assign bus.wb_dat_o  = r_dat_o;
endmodule

// File: doc/wb_init_master.md
WB_INIT_MASTER -- requirements
Module: wb_init_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024, max wait cycles for ack per beat (range 2..65535).
REQ-002 SHALL have ports (name  direction  width  meaning):
- wb_clk_i  in  1  sole clock.
- wb_resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted.
- cmd_we  in  1  1=write, 0=read.
- cmd_addr  in  32  start byte address.
- cmd_sel  in  4  byte lanes, used for every beat.
- cmd_len  in  8  beats minus one (1..256 beats).
- wr_data  in  32  write data stream.
- wr_valid  in  1  write data present.
- wr_ready  out  1  write data taken.
- rd_data  out  32  read data.
- rd_valid  out  1  read data strobe.
- done  out  1  command completed OK.
- err  out  1  command aborted.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe, write enable.
- wb_adr_o  out  32  address.
- wb_sel_o  out  4  byte select.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i  in  1 each  slave ack, slave error.

Function
REQ-003 SHALL implement states IDLE, WDAT, BUS, FIN; all outputs registered.
REQ-004 IDLE: cmd_ready=1; on cmd_valid&cmd_ready SHALL latch we/addr/sel, set beat counter to cmd_len+1, go to WDAT if write, else BUS.
REQ-005 WDAT: wr_ready=1; on wr_valid SHALL load wb_dat_o, go to BUS; cyc/stb stay 0 on the first beat.
REQ-006 Entry into BUS SHALL assert wb_cyc_o and wb_stb_o on the same edge; wb_stb_o SHALL never be 1 while wb_cyc_o is 0.
REQ-007 BUS, ack with stb high: read SHALL register wb_dat_i to rd_data with a one-cycle rd_valid pulse in the following cycle; address +4, wrapping modulo 2^32; counter decrements.
REQ-008 After a non-last read ack, stb SHALL stay high with the next address; after a non-last write ack, stb SHALL drop, cyc SHALL stay high, and the state SHALL return to WDAT.
REQ-009 Last-beat ack SHALL go to FIN: cyc/stb/we low, done pulses 1 cycle, then IDLE.
REQ-010 wb_err_i with stb high SHALL abort: cyc/stb drop next edge, err pulses 1 cycle, no done, IDLE.
REQ-011 ack and err in the same cycle SHALL be treated as err; ack/err while stb low SHALL be ignored.
REQ-012 wb_we_o, wb_sel_o, wb_adr_o SHALL be stable while stb is high.

Reset
REQ-013 wb_resetn low SHALL, asynchronously, force IDLE and all outputs (incl. cmd_ready, wb_adr_o, wb_dat_o, rd_data) to 0.
REQ-014 cmd_ready SHALL rise on the first wb_clk_i edge after release; reset mid-burst SHALL drop cyc/stb immediately, with no done/err.

Configuration
REQ-015 With WB_INIT_MASTER_TIMEOUT_EN defined, a per-beat counter SHALL clear on stb rise and on each ack, and on reaching TIMEOUT_CYC with no ack SHALL abort exactly as REQ-010.
REQ-016 Without WB_INIT_MASTER_TIMEOUT_EN, no counter SHALL exist, and BUS SHALL wait indefinitely.

Verification
REQ-017 Read cmd_addr=0x100, len=0, ack after 3 cycles, dat_i=0xDEADBEEF -> one cyc/stb cycle, rd_data=0xDEADBEEF, rd_valid 1 cycle, done 1 cycle.
REQ-018 Write len=3, sel=0xF, data 1..4, ack 1 cycle after each stb -> adr 0x0/0x4/0x8/0xC, dat_o 1..4, cyc continuous, stb low between beats, done once.
REQ-019 Read len=1, addr=0xFFFFFFFC -> second beat adr=0x00000000.
REQ-020 Read len=2, wb_err_i at beat 2 -> err 1 cycle, cyc/stb low next edge, no done, third beat never issued.
REQ-021 Timeout enabled, TIMEOUT_CYC=8, no ack -> abort exactly 8 cycles after stb rise; disabled -> stb held 1000 cycles.
REQ-022 Reset asserted mid-write burst -> all outputs 0 asynchronously; cmd_ready=1 one edge after release.
